// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared constants and helpers for the register-to-UART
//               transmitter: parity modes, FSM state encoding, baud divisor
//               and parity computation.
// Revision    : 2.0 - parametrised successor with FIFO and byte ordering
// ============================================================================
package uart_tx_pkg;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Serializer FSM state encoding
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Clock cycles per UART bit; clk_fre is in MHz
  function automatic int clks_per_bit(input int clk_fre, input int bps);
    return (clk_fre * 1000000) / bps;
  endfunction

  // Parity bit for one data byte; a line-idle 1 is returned when parity is off
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    if (mode == PAR_EVEN) begin
      return ^data;
    end else if (mode == PAR_ODD) begin
      return ~(^data);
    end
    return 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sync_fifo
// Description : Single-clock FIFO with a word-count level output. Read data
//               is shown at the head combinationally so a pop and its load
//               happen in the same cycle. Pointers wrap modulo DEPTH; the
//               level counter tells full from empty.
// Revision    : 2.0 - initial parametrised version
// ============================================================================
module uart_tx_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and level update; simultaneous push and pop keep the level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage array; contents need no reset since the level gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_reg_tx_v2.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_tx_v2
// Description : Register-to-UART transmitter. Words enter a FIFO through a
//               valid/ready handshake, are split into bytes in a selectable
//               order and sent as UART frames with optional parity and one
//               or two stop bits. Consecutive bytes and words go out with no
//               idle gap.
// Revision    : 2.0 - parametrised successor with FIFO and byte ordering
// ============================================================================
module uart_reg_tx_v2
  import uart_tx_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BPS        = 115200,
  parameter int REG_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BYTE_ORDER = 0,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_WIDTH-1:0]          uart_tx_reg,
  input  logic                          uart_tx_valid,
  output logic                          uart_tx_ready,
  output logic                          uart_tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB    = clks_per_bit(CLK_FRE, BPS);
  localparam int CNT_W  = $clog2(CPB);
  localparam int NBYTES = REG_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NBYTES - 1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [REG_WIDTH-1:0] word_q, word_d;
  logic                 pin_q, pin_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [REG_WIDTH-1:0] fifo_rdata;
  logic                 bit_end;
  logic                 last_stop;
  logic [IDX_W-1:0]     sel_idx;
  logic [7:0]           cur_byte;

  uart_tx_sync_fifo #(
    .WIDTH (REG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_tx_valid && uart_tx_ready),
    .wdata (uart_tx_reg),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign uart_tx_ready = !fifo_full;
  assign tx_busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign uart_tx_pin   = pin_q;
  assign bit_end       = (baud_cnt_q == CNT_LAST);
  assign last_stop     = (STOP_BITS < 2) ? 1'b1 : stop_cnt_q;

  // Serializer next state: bit timing, byte stepping and FIFO pops
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    stop_cnt_d = stop_cnt_q;
    word_d     = word_q;
    fifo_pop   = 1'b0;
    if (state_q == ST_IDLE) begin
      baud_cnt_d = '0;
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        word_d     = fifo_rdata;
        byte_idx_d = '0;
        bit_idx_d  = '0;
        stop_cnt_d = 1'b0;
        state_d    = ST_START;
      end
    end else begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      if (bit_end) begin
        case (state_q)
          ST_START: begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
          ST_DATA: begin
            if (bit_idx_q == 3'd7) begin
              state_d    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              stop_cnt_d = 1'b0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
          ST_PARITY: begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
          end
          ST_STOP: begin
            if (!last_stop) begin
              stop_cnt_d = 1'b1;
            end else if (byte_idx_q != LAST_BYTE) begin
              byte_idx_d = byte_idx_q + 1'b1;
              state_d    = ST_START;
            end else if (!fifo_empty) begin
              // Next word follows immediately after the final stop bit
              fifo_pop   = 1'b1;
              word_d     = fifo_rdata;
              byte_idx_d = '0;
              state_d    = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Line level for the upcoming cycle, so the pin itself is a flop
  always_comb begin
    sel_idx  = (BYTE_ORDER != 0) ? (LAST_BYTE - byte_idx_d) : byte_idx_d;
    cur_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (sel_idx == IDX_W'(k)) begin
        cur_byte = word_d[8*k +: 8];
      end
    end
    case (state_d)
      ST_START:  pin_d = 1'b0;
      ST_DATA:   pin_d = cur_byte[bit_idx_d];
      ST_PARITY: pin_d = parity_bit(cur_byte, PARITY);
      default:   pin_d = 1'b1;
    endcase
  end

  // Serializer registers; reset drops any partial frame and idles the line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      stop_cnt_q <= 1'b0;
      word_q     <= '0;
      pin_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      stop_cnt_q <= stop_cnt_d;
      word_q     <= word_d;
      pin_q      <= pin_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_tx_v2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_tx_v2
// Description : Self-checking bench for uart_reg_tx_v2. Five instances cover
//               byte order, parity, stop bits and FIFO depth; a frame monitor
//               on the selected instance compares every line cycle against
//               expected bytes queued when words are accepted.
// Revision    : 2.0 - initial bench
// ============================================================================
module tb_uart_reg_tx_v2;

  localparam int NI = 5;

  logic          clk = 1'b0;
  int            cyc = 0;
  logic [NI-1:0] rstv;
  logic [NI-1:0] vld;
  logic [15:0]   din;
  logic [NI-1:0] w_pin;
  logic [NI-1:0] w_rdy;
  logic [NI-1:0] w_busy;
  logic [4:0]    lvl0, lvl1, lvl2, lvl3;
  logic [2:0]    lvl4;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int         starts[$];
  int         sel = 0;
  int         par_of [NI] = '{0, 2, 1, 0, 0};
  int         sb_of  [NI] = '{1, 1, 1, 2, 1};
  int         bo_of  [NI] = '{0, 1, 1, 0, 0};

  // Clock; cyc counts rising edges and is updated before the edge is seen
  initial begin
    forever begin
      #5 cyc = cyc + 1;
      clk = 1'b1;
      #5 clk = 1'b0;
    end
  end

  uart_reg_tx_v2 #(.CLK_FRE(1), .BPS(250000), .REG_WIDTH(16), .FIFO_DEPTH(16),
                   .BYTE_ORDER(0), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rstv[0]), .uart_tx_reg(din), .uart_tx_valid(vld[0]),
    .uart_tx_ready(w_rdy[0]), .uart_tx_pin(w_pin[0]), .tx_busy(w_busy[0]),
    .fifo_level(lvl0));

  uart_reg_tx_v2 #(.CLK_FRE(1), .BPS(250000), .REG_WIDTH(16), .FIFO_DEPTH(16),
                   .BYTE_ORDER(1), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rstv[1]), .uart_tx_reg(din), .uart_tx_valid(vld[1]),
    .uart_tx_ready(w_rdy[1]), .uart_tx_pin(w_pin[1]), .tx_busy(w_busy[1]),
    .fifo_level(lvl1));

  uart_reg_tx_v2 #(.CLK_FRE(1), .BPS(250000), .REG_WIDTH(16), .FIFO_DEPTH(16),
                   .BYTE_ORDER(1), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rstv[2]), .uart_tx_reg(din), .uart_tx_valid(vld[2]),
    .uart_tx_ready(w_rdy[2]), .uart_tx_pin(w_pin[2]), .tx_busy(w_busy[2]),
    .fifo_level(lvl2));

  uart_reg_tx_v2 #(.CLK_FRE(1), .BPS(250000), .REG_WIDTH(16), .FIFO_DEPTH(16),
                   .BYTE_ORDER(0), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rstv[3]), .uart_tx_reg(din), .uart_tx_valid(vld[3]),
    .uart_tx_ready(w_rdy[3]), .uart_tx_pin(w_pin[3]), .tx_busy(w_busy[3]),
    .fifo_level(lvl3));

  uart_reg_tx_v2 #(.CLK_FRE(1), .BPS(250000), .REG_WIDTH(16), .FIFO_DEPTH(4),
                   .BYTE_ORDER(0), .PARITY(0), .STOP_BITS(1)) u_dut4 (
    .clk(clk), .rst(rstv[4]), .uart_tx_reg(din), .uart_tx_valid(vld[4]),
    .uart_tx_ready(w_rdy[4]), .uart_tx_pin(w_pin[4]), .tx_busy(w_busy[4]),
    .fifo_level(lvl4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: every cycle of a frame must match the expected bit
  logic        in_frame = 1'b0;
  int          fcnt = 0;
  int          nbits = 0;
  logic        fok = 1'b1;
  logic [11:0] fbits = '1;
  logic [11:0] rbits = '1;
  logic [7:0]  eb = 8'h00;

  always @(negedge clk) begin
    if (rstv[sel]) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && w_pin[sel] == 1'b0) begin
        n_checks++;
        assert (exp_q.size() > 0) else begin
          n_errors++;
          $error("FAIL frame_expected: observed=start bit expected=no frame (queue empty)");
        end
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        fbits      = '1;
        fbits[0]   = 1'b0;
        fbits[8:1] = eb;
        nbits      = 9;
        if (par_of[sel] != 0) begin
          fbits[9] = (par_of[sel] == 1) ? ~(^eb) : (^eb);
          nbits    = 10;
        end
        nbits    = nbits + sb_of[sel];
        rbits    = '1;
        fok      = 1'b1;
        fcnt     = 0;
        in_frame = 1'b1;
        starts.push_back(cyc);
      end
      if (in_frame) begin
        if (w_pin[sel] !== fbits[fcnt/4]) fok = 1'b0;
        if (fcnt % 4 == 2) rbits[fcnt/4] = w_pin[sel];
        fcnt++;
        if (fcnt == nbits * 4) begin
          in_frame = 1'b0;
          chk("frame", {19'b0, fok, rbits}, {19'b0, 1'b1, fbits});
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(posedge clk);
    #1;
  endtask

  task automatic sample_at(input int t);
    while (cyc < t) @(posedge clk);
    @(negedge clk);
  endtask

  // Offer consecutive words w0, w0+1, ... for ncyc cycles; queue bytes of accepted ones
  task automatic send(input int inst, input logic [15:0] w0, input int ncyc, output int nacc);
    logic [15:0] w;
    nacc = 0;
    for (int c = 0; c < ncyc; c++) begin
      w = w0 + 16'(c);
      din = w;
      vld[inst] = 1'b1;
      if (w_rdy[inst]) begin
        nacc++;
        if (bo_of[inst] == 0) begin
          exp_q.push_back(w[7:0]);
          exp_q.push_back(w[15:8]);
        end else begin
          exp_q.push_back(w[15:8]);
          exp_q.push_back(w[7:0]);
        end
      end
      @(posedge clk);
      #1;
    end
    vld[inst] = 1'b0;
  endtask

  task automatic wait_idle(input int inst, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || in_frame || w_busy[inst]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'b0, (n < budget)}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int N;
    int nacc;
    int nbad;
    rstv = '1;
    vld  = '0;
    din  = '0;
    repeat (3) @(posedge clk);
    #1;
    rstv = '0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_pin",   {31'b0, w_pin[i]},  32'd1);
      chk("reset_ready", {31'b0, w_rdy[i]},  32'd1);
      chk("reset_busy",  {31'b0, w_busy[i]}, 32'd0);
    end
    chk("reset_level", {9'b0, lvl0, lvl1, lvl2, lvl3, lvl4}, 32'd0);

    // LSB-first, no parity, one stop bit
    sel = 0;
    starts.delete();
    N = cyc;
    send(0, 16'hA55A, 1, nacc);
    sample_at(N + 1);
    chk("a_pin_before_start", {31'b0, w_pin[0]}, 32'd1);
    chk("a_busy_queued", {31'b0, w_busy[0]}, 32'd1);
    sample_at(N + 2);
    chk("a_start_bit", {31'b0, w_pin[0]}, 32'd0);
    sample_at(N + 81);
    chk("a_last_stop_pin", {31'b0, w_pin[0]}, 32'd1);
    chk("a_busy_last_stop", {31'b0, w_busy[0]}, 32'd1);
    sample_at(N + 82);
    chk("a_idle_pin", {31'b0, w_pin[0]}, 32'd1);
    chk("a_busy_fall", {31'b0, w_busy[0]}, 32'd0);
    chk("a_frames", starts.size(), 32'd2);
    chk("a_first_start", starts[0], N + 2);
    chk("a_byte_gap", starts[1] - starts[0], 32'd40);
    chk("a_queue_drained", exp_q.size(), 32'd0);

    // MSB-first, even parity
    sel = 1;
    starts.delete();
    N = cyc;
    send(1, 16'hA55A, 1, nacc);
    sample_at(N + 7);
    chk("b_first_lsb", {31'b0, w_pin[1]}, 32'd1);
    sample_at(N + 39);
    chk("b_parity0", {31'b0, w_pin[1]}, 32'd0);
    sample_at(N + 83);
    chk("b_parity1", {31'b0, w_pin[1]}, 32'd0);
    wait_idle(1, 200);
    chk("b_byte_gap", starts[1] - starts[0], 32'd44);

    // MSB-first, odd parity
    sel = 2;
    starts.delete();
    N = cyc;
    send(2, 16'hA55A, 1, nacc);
    sample_at(N + 39);
    chk("c_parity0", {31'b0, w_pin[2]}, 32'd1);
    sample_at(N + 83);
    chk("c_parity1", {31'b0, w_pin[2]}, 32'd1);
    wait_idle(2, 200);

    // Two stop bits
    sel = 3;
    starts.delete();
    N = cyc;
    send(3, 16'h00FF, 1, nacc);
    sample_at(N + 38);
    chk("d_stop_first", {31'b0, w_pin[3]}, 32'd1);
    sample_at(N + 45);
    chk("d_stop_last", {31'b0, w_pin[3]}, 32'd1);
    sample_at(N + 46);
    chk("d_next_start", {31'b0, w_pin[3]}, 32'd0);
    wait_idle(3, 200);
    chk("d_byte_gap", starts[1] - starts[0], 32'd44);

    // Depth-4 FIFO with valid held for 8 cycles
    sel = 4;
    starts.delete();
    N = cyc;
    send(4, 16'h1000, 8, nacc);
    chk("e_accepted", nacc, 32'd5);
    sample_at(N + 8);
    chk("e_level_full", {29'b0, lvl4}, 32'd4);
    chk("e_ready_full", {31'b0, w_rdy[4]}, 32'd0);
    sample_at(N + 81);
    chk("e_level_before_pop", {29'b0, lvl4}, 32'd4);
    chk("e_ready_before_pop", {31'b0, w_rdy[4]}, 32'd0);
    sample_at(N + 82);
    chk("e_level_after_pop", {29'b0, lvl4}, 32'd3);
    chk("e_ready_after_pop", {31'b0, w_rdy[4]}, 32'd1);
    wait_idle(4, 600);
    chk("e_frames", starts.size(), 32'd10);
    nbad = 0;
    for (int k = 1; k < starts.size(); k++) begin
      if (starts[k] - starts[k-1] != 40) nbad++;
    end
    chk("e_gapless", nbad, 32'd0);

    // Push coinciding with the pop at level 2
    sel = 0;
    starts.delete();
    N = cyc;
    send(0, 16'h1111, 3, nacc);
    sample_at(N + 80);
    chk("f_level_before", {27'b0, lvl0}, 32'd2);
    goto(N + 81);
    send(0, 16'h2222, 1, nacc);
    chk("f_push_accepted", nacc, 32'd1);
    sample_at(N + 82);
    chk("f_level_same", {27'b0, lvl0}, 32'd2);
    wait_idle(0, 500);
    chk("f_frames", starts.size(), 32'd8);

    // Reset during data bit 3 of the second byte with two words queued
    starts.delete();
    N = cyc;
    send(0, 16'h3333, 3, nacc);
    sample_at(N + 58);
    chk("g_level_queued", {27'b0, lvl0}, 32'd2);
    chk("g_data_bit3", {31'b0, w_pin[0]}, 32'd0);
    goto(N + 59);
    rstv[0] = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rstv[0] = 1'b0;
    sample_at(N + 60);
    chk("g_pin_after_rst", {31'b0, w_pin[0]}, 32'd1);
    chk("g_level_after_rst", {27'b0, lvl0}, 32'd0);
    chk("g_busy_after_rst", {31'b0, w_busy[0]}, 32'd0);
    N = cyc;
    send(0, 16'h4444, 1, nacc);
    sample_at(N + 1);
    chk("g_pin_pre_start", {31'b0, w_pin[0]}, 32'd1);
    sample_at(N + 2);
    chk("g_clean_start", {31'b0, w_pin[0]}, 32'd0);
    wait_idle(0, 200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
